// File: rtl/gf2m_trinomial_reducer.sv
// Sequential GF(2^M) reducer: folds a (2M-1)-bit carry-less product modulo x^M + x^K + 1,
// S bits per clock from the top down, with valid/ready on both sides.
module gf2m_trinomial_reducer #(
    parameter int M = 409,
    parameter int K = 87,
    parameter int S = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-2:0] in_poly,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_poly,
    output logic           busy
);

    localparam int W  = 2 * M - 1;
    localparam int TW = $clog2(2 * M) + 1;

    generate
        if (K <= 0 || K >= M || S < 1 || S > M - K) begin : g_param_check
            $error("gf2m_trinomial_reducer: need 0 < K < M and 1 <= S <= M-K");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    r;
    logic [TW-1:0]   t;
    logic [TW-1:0]   lo;
    logic            last_chunk;
    logic [W-1:0]    r_next;

    // Every fold target lies below the chunk's lower bound, so reading the
    // unmodified r for chunk bits is exact and targets simply accumulate by XOR.
    always_comb begin
        if (t >= TW'(M + S - 1)) begin
            lo = t - TW'(S - 1);
        end else begin
            lo = TW'(M);
        end
        last_chunk = (lo == TW'(M));
        r_next = r;
        for (int j = M; j < W; j++) begin
            if (j >= int'(lo) && j <= int'(t) && r[j]) begin
                r_next[j]         = 1'b0;
                r_next[j - M]     = r_next[j - M] ^ 1'b1;
                r_next[j - M + K] = r_next[j - M + K] ^ 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_poly  <= '0;
            r         <= '0;
            t         <= TW'(2 * M - 2);
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r        <= in_poly;
                        t        <= TW'(2 * M - 2);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FOLD;
                    end
                end
                FOLD: begin
                    r <= r_next;
                    t <= t - TW'(S);
                    if (last_chunk) begin
                        out_poly <= r_next[M-1:0];
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE, then waits for the sink.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_trinomial_reducer.sv
// Bench for gf2m_trinomial_reducer at the B-409 defaults: directed corner cases, random a*b
// products against an interleaved modular-multiply model, backpressure and mid-fold reset.
module tb_gf2m_trinomial_reducer;

    localparam int M = 409;
    localparam int K = 87;
    localparam int S = 64;
    localparam int W = 2 * M - 1;
    localparam int N = (M - 1 + S - 1) / S;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_poly;
    logic           out_valid;
    logic           out_ready;
    logic [M-1:0]   out_poly;
    logic           busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    gf2m_trinomial_reducer #(.M(M), .K(K), .S(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_poly  (in_poly),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_poly (out_poly),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Field multiply by shift-and-add with reduction after every doubling.
    function automatic logic [M-1:0] mod_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc = '0;
        logic         carry;
        for (int i = M - 1; i >= 0; i--) begin
            carry = acc[M-1];
            acc   = {acc[M-2:0], 1'b0};
            if (carry) begin
                acc[K] = ~acc[K];
                acc[0] = ~acc[0];
            end
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] cl_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [W-1:0] p = '0;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ (W'(a) << i);
        end
        return p;
    endfunction

    function automatic logic [M-1:0] rand_elem();
        logic [M+31:0] tmp = '0;
        for (int w = 0; w < M; w += 32) tmp[w +: 32] = $urandom;
        return tmp[M-1:0];
    endfunction

    // Presents p, then counts edges after the accept edge until out_valid (-1 on timeout).
    task automatic applyStimulus(input logic [W-1:0] p, output int lat);
        int guard = 0;
        lat = -1;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (in_ready) begin
            in_poly  = p;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 100) begin
                step();
                lat++;
            end
            if (!out_valid) lat = -1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [M-1:0] exp);
        check_bit({tag, ".out_valid"}, out_valid, 1'b1);
        check_bit({tag, ".busy"}, busy, 1'b1);
        check_vec({tag, ".out_poly"}, out_poly, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_bit({tag, ".in_ready_after"}, in_ready, 1'b1);
        check_bit({tag, ".out_valid_after"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] p;
        logic [M-1:0] e;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] held;
        int           lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_poly   = '0;
        step();
        step();
        rst = 1'b0;
        check_bit("reset.in_ready", in_ready, 1'b1);
        check_bit("reset.out_valid", out_valid, 1'b0);
        check_bit("reset.busy", busy, 1'b0);
        check_vec("reset.out_poly", out_poly, '0);

        applyStimulus('0, lat);
        check_int("zero.latency", lat + 1, N + 2);
        checkOutput("zero", '0);

        p = '0; p[408] = 1'b1;
        e = '0; e[408] = 1'b1;
        applyStimulus(p, lat);
        check_int("x408.latency", lat + 1, N + 2);
        checkOutput("x408", e);

        p = '0; p[409] = 1'b1;
        e = '0; e[87] = 1'b1; e[0] = 1'b1;
        applyStimulus(p, lat);
        checkOutput("x409", e);

        p = '0; p[816] = 1'b1;
        e = '0; e[407] = 1'b1; e[172] = 1'b1; e[85] = 1'b1;
        applyStimulus(p, lat);
        checkOutput("x816", e);

        for (int v = 0; v < 1000; v++) begin
            a = rand_elem();
            b = rand_elem();
            applyStimulus(cl_mul(a, b), lat);
            checkOutput("random", mod_mul(a, b));
        end

        p = '0; p[409] = 1'b1;
        e = '0; e[87] = 1'b1; e[0] = 1'b1;
        applyStimulus(p, lat);
        held     = out_poly;
        in_poly  = cl_mul(rand_elem(), rand_elem());
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            check_bit("bp.out_valid", out_valid, 1'b1);
            check_bit("bp.in_ready", in_ready, 1'b0);
            check_vec("bp.out_poly", out_poly, held);
        end
        in_valid = 1'b0;
        checkOutput("bp", e);
        check_bit("bp.no_accept", busy, 1'b0);

        p = '0; p[816] = 1'b1;
        in_poly  = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_bit("abort.in_ready", in_ready, 1'b1);
        check_bit("abort.out_valid", out_valid, 1'b0);
        check_bit("abort.busy", busy, 1'b0);
        check_vec("abort.out_poly", out_poly, '0);

        p = '0; p[409] = 1'b1;
        applyStimulus(p, lat);
        check_int("post_abort.latency", lat + 1, N + 2);
        checkOutput("post_abort", e);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
